// File: rtl/add_sub_seq.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB first,
// with valid/ready handshakes on both sides and a per-transaction mode.
module add_sub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_var1,
  input  logic [WIDTH-1:0] i_var2,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_res,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 state;
  logic [WIDTH-1:0]       a_q;
  logic [WIDTH-1:0]       b_q;
  logic                   carry_q;
  logic [CW-1:0]          cnt;

  logic [CHUNK:0]         chunk_sum;
  logic [WIDTH+CHUNK-1:0] res_cat;
  logic                   last;
  logic                   ovf_chunk;

  // Operands are shifted right each cycle so the current chunk always sits
  // in the low CHUNK bits; the result fills from the top and is fully
  // aligned once the last chunk has been shifted in.
  always_comb begin
    chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
              + {{CHUNK{1'b0}}, carry_q};
    res_cat   = {chunk_sum[CHUNK-1:0], o_res};
    last      = (cnt == CW'(NCHUNK - 1));
    // b_q already holds ~i_var2 for subtract, so one rule covers both modes
    ovf_chunk = (a_q[CHUNK-1] == b_q[CHUNK-1]) &&
                (chunk_sum[CHUNK-1] != a_q[CHUNK-1]);
  end

  // Control FSM and datapath registers, all outputs registered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      cnt        <= '0;
      o_ready    <= 1'b1;
      o_valid    <= 1'b0;
      o_res      <= '0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_q     <= i_var1;
            b_q     <= i_mode ? i_var2 : ~i_var2;
            carry_q <= ~i_mode;
            cnt     <= '0;
            o_ready <= 1'b0;
            state   <= CALC;
          end
        end
        CALC: begin
          o_res   <= res_cat[WIDTH+CHUNK-1:CHUNK];
          carry_q <= chunk_sum[CHUNK];
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          cnt     <= cnt + 1'b1;
          if (last) begin
            o_carry    <= chunk_sum[CHUNK];
            o_overflow <= ovf_chunk;
            o_valid    <= 1'b1;
            cnt        <= '0;
            state      <= DONE;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
